// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared types and helpers for the pulse stretcher.
// State encoding is fixed so that waveform viewers and board-level probes
// see the same codes across builds.
package pulse_stretch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Larger of two widths; sizes the counter shared by the ON and GAP phases.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_updown.sv
// sat_updown: saturating up/down counter holding the number of queued events.
// inc and dec in the same cycle cancel out. The value never wraps: it holds
// at all-ones on inc and at zero on dec. sat flags the all-ones value so the
// owner can tell that an increment was lost.
module sat_updown
  import pulse_stretch_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         sat
);

  localparam logic [W-1:0] VAL_MAX = '1;

  logic up_ok;
  logic dn_ok;

  assign up_ok = inc & ~dec & (value != VAL_MAX);
  assign dn_ok = dec & ~inc & (value != '0);
  assign sat   = (value == VAL_MAX);

  // Counter register with synchronous reset; blocked steps leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (up_ok) begin
      value <= value + 1'b1;
    end else if (dn_ok) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle event strobes into long visible pulses.
// Each event gives 2^ON_W cycles of OUT high followed by at least 2^OFF_W
// cycles low, so back-to-back events stay distinguishable on the pin.
//
// Build option: PULSE_STRETCH_QUEUE_EN
//   defined     - events arriving during a pulse are queued (saturating) and
//                 replayed back to back; an event lost to saturation pulses DROP.
//   not defined - no queue; PEND is tied to zero and any event arriving while
//                 busy is discarded with DROP.
//
// state | meaning
// IDLE  | no pulse in progress, OUT low, waiting for EV
// ON    | OUT high, CNT counts 0 .. 2^ON_W-1
// GAP   | OUT low, CNT counts 0 .. 2^OFF_W-1, then start queued pulse or idle
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int ON_W     = 16,
  parameter int OFF_W    = 16,
  parameter int QDEPTH_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EV,
  output logic                OUT,
  output logic                BUSY,
  output logic                DROP,
  output logic [QDEPTH_W-1:0] PEND
);

  localparam int CNT_W = max_int(ON_W, OFF_W);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'({ON_W{1'b1}});
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'({OFF_W{1'b1}});

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             busy_now;
  logic             start_next;
  logic             drop_nxt;

  assign busy_now = (state != IDLE);

`ifdef PULSE_STRETCH_QUEUE_EN
  logic                gap_done;
  logic                pend_inc;
  logic                pend_dec;
  logic                pend_sat;
  logic [QDEPTH_W-1:0] pend_val;

  // At the last GAP cycle a same-cycle event counts as pending, so it can
  // start the next pulse directly even when the queue is empty; the
  // increment and the consume then cancel and PEND is unchanged.
  assign gap_done   = (state == GAP) && (cnt == GAP_LAST);
  assign start_next = gap_done & ((pend_val != '0) | EV);
  assign pend_inc   = EV & busy_now;
  assign pend_dec   = start_next;
  assign drop_nxt   = pend_inc & ~pend_dec & pend_sat;

  sat_updown #(
    .W (QDEPTH_W)
  ) u_pend (
    .clk   (CLK),
    .rst   (RST),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .value (pend_val),
    .sat   (pend_sat)
  );

  assign PEND = pend_val;
`else
  // Without a queue every event seen while busy is lost, including one that
  // lands on the last GAP cycle.
  assign start_next = 1'b0;
  assign drop_nxt   = EV & busy_now;
  assign PEND       = '0;
`endif

  // State and phase counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter update; the counter restarts at every phase change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (EV) begin
          state_nxt = ON;
          cnt_nxt   = '0;
        end
      end
      ON: begin
        if (cnt == ON_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = start_next ? ON : IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pin-facing outputs are registered from the next state so they change
  // in the same cycle as the state itself and never glitch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT  <= 1'b0;
      BUSY <= 1'b0;
      DROP <= 1'b0;
    end else begin
      OUT  <= (state_nxt == ON);
      BUSY <= (state_nxt != IDLE);
      DROP <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed scenarios plus randomized traffic against a
// timestamp-based model of the pulse stretcher (ON_W=3, OFF_W=2, QDEPTH_W=2).
// Follows the PULSE_STRETCH_QUEUE_EN build option of the design.
module tb_pulse_stretch;

  localparam int ON_W     = 3;
  localparam int OFF_W    = 2;
  localparam int QDEPTH_W = 2;
  localparam int ON_LEN   = 1 << ON_W;
  localparam int OFF_LEN  = 1 << OFF_W;
  localparam int QMAX     = (1 << QDEPTH_W) - 1;
  localparam int HLEN     = 8192;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                ev  = 1'b0;
  logic                out_pin;
  logic                busy;
  logic                drop;
  logic [QDEPTH_W-1:0] pend;

  pulse_stretch #(
    .ON_W     (ON_W),
    .OFF_W    (OFF_W),
    .QDEPTH_W (QDEPTH_W)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .EV   (ev),
    .OUT  (out_pin),
    .BUSY (busy),
    .DROP (drop),
    .PEND (pend)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: a pulse is a time window [start, start+ON_LEN+OFF_LEN); OUT is
  // high in its first ON_LEN cycles. Queued events are a plain count.
  bit m_seen_rst = 1'b0;
  bit m_active   = 1'b0;
  int m_start    = 0;
  int m_pend     = 0;
  bit m_drop     = 1'b0;

  logic       h_out  [HLEN];
  logic       h_busy [HLEN];
  logic       h_drop [HLEN];
  logic [1:0] h_pend [HLEN];

  always @(posedge clk) begin
    int c;
    int eff;
    bit terminal;
    c   = cyc;
    cyc = cyc + 1;
    if (rst) begin
      m_seen_rst = 1'b1;
      m_active   = 1'b0;
      m_pend     = 0;
      m_drop     = 1'b0;
    end else begin
      m_drop = 1'b0;
      if (!m_active) begin
        if (ev) begin
          m_active = 1'b1;
          m_start  = c + 1;
        end
      end else begin
        terminal = (c == m_start + ON_LEN + OFF_LEN - 1);
`ifdef PULSE_STRETCH_QUEUE_EN
        eff = m_pend + (ev ? 1 : 0);
        if (terminal) begin
          if (eff > 0) begin
            m_start = c + 1;
            m_pend  = eff - 1;
          end else begin
            m_active = 1'b0;
          end
        end else if (eff > QMAX) begin
          m_drop = 1'b1;
          m_pend = QMAX;
        end else begin
          m_pend = eff;
        end
`else
        eff = 0;
        if (ev) m_drop = 1'b1;
        if (terminal) m_active = 1'b0;
`endif
      end
    end
  end

  // Compare process: every cycle after the first reset, DUT vs model.
  always @(negedge clk) begin
    logic       e_out;
    logic [1:0] e_pend;
    if (cyc < HLEN) begin
      h_out[cyc]  = out_pin;
      h_busy[cyc] = busy;
      h_drop[cyc] = drop;
      h_pend[cyc] = pend;
    end
    if (m_seen_rst) begin
      e_out  = m_active && ((cyc - m_start) < ON_LEN);
      e_pend = 2'(m_pend);
      n_vec  = n_vec + 1;
      if (out_pin !== e_out || busy !== m_active || drop !== m_drop || pend !== e_pend) begin
        n_err = n_err + 1;
        if (n_err <= 20)
          $display("FAIL cycle_%0d: got out=%b busy=%b drop=%b pend=%0d, want out=%b busy=%b drop=%b pend=%0d",
                   cyc, out_pin, busy, drop, pend, e_out, m_active, m_drop, e_pend);
      end
    end
  end

  task automatic tick(input logic e, input logic r);
    @(negedge clk);
    ev  = e;
    rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  int base;
  int dens;
  int ndrop;

  initial begin
    // Single event from IDLE.
    do_reset();
    check("reset_out", 4'(out_pin), 4'd0);
    check("reset_busy", 4'(busy), 4'd0);
    check("reset_pend", 4'(pend), 4'd0);
    tick(1'b1, 1'b0);
    base = cyc;
    idle(20);
    check("s1_out_c1", 4'(h_out[base+1]), 4'd1);
    check("s1_out_c8", 4'(h_out[base+8]), 4'd1);
    check("s1_out_c9", 4'(h_out[base+9]), 4'd0);
    check("s1_out_c12", 4'(h_out[base+12]), 4'd0);
    check("s1_busy_c12", 4'(h_busy[base+12]), 4'd1);
    check("s1_busy_c13", 4'(h_busy[base+13]), 4'd0);
    ndrop = 0;
    for (int i = 0; i < 20; i++) ndrop += int'(h_drop[base+i]);
    check("s1_no_drop", 4'(ndrop), 4'd0);

    // Two events at cycles 0 and 3.
    do_reset();
    tick(1'b1, 1'b0);
    base = cyc;
    idle(2);
    tick(1'b1, 1'b0);
    idle(25);
`ifdef PULSE_STRETCH_QUEUE_EN
    check("s2_pend_c3", 4'(h_pend[base+3]), 4'd0);
    check("s2_pend_c4", 4'(h_pend[base+4]), 4'd1);
    check("s2_out_c13", 4'(h_out[base+13]), 4'd1);
    check("s2_pend_c13", 4'(h_pend[base+13]), 4'd0);
    check("s2_out_c20", 4'(h_out[base+20]), 4'd1);
    check("s2_out_c21", 4'(h_out[base+21]), 4'd0);
    check("s2_busy_c25", 4'(h_busy[base+25]), 4'd0);
`else
    check("s2_drop_c4", 4'(h_drop[base+4]), 4'd1);
    check("s2_pend_c4", 4'(h_pend[base+4]), 4'd0);
    check("s2_out_c13", 4'(h_out[base+13]), 4'd0);
    check("s2_busy_c13", 4'(h_busy[base+13]), 4'd0);
`endif

    // Event held high for 5 cycles.
    do_reset();
    tick(1'b1, 1'b0);
    base = cyc;
    repeat (4) tick(1'b1, 1'b0);
    idle(55);
`ifdef PULSE_STRETCH_QUEUE_EN
    check("s3_pend_c4", 4'(h_pend[base+4]), 4'd3);
    check("s3_drop_c4", 4'(h_drop[base+4]), 4'd0);
    check("s3_drop_c5", 4'(h_drop[base+5]), 4'd1);
    check("s3_drop_c6", 4'(h_drop[base+6]), 4'd0);
    check("s3_out_c37", 4'(h_out[base+37]), 4'd1);
    check("s3_out_c44", 4'(h_out[base+44]), 4'd1);
    check("s3_out_c45", 4'(h_out[base+45]), 4'd0);
    check("s3_busy_c48", 4'(h_busy[base+48]), 4'd1);
    check("s3_busy_c49", 4'(h_busy[base+49]), 4'd0);
`else
    check("s3_drop_c2", 4'(h_drop[base+2]), 4'd1);
    check("s3_drop_c5", 4'(h_drop[base+5]), 4'd1);
    check("s3_out_c13", 4'(h_out[base+13]), 4'd0);
`endif

    // Event on the last GAP cycle with nothing queued.
    do_reset();
    tick(1'b1, 1'b0);
    base = cyc;
    idle(11);
    tick(1'b1, 1'b0);
    idle(20);
    check("s4_out_c12", 4'(h_out[base+12]), 4'd0);
    check("s4_busy_c12", 4'(h_busy[base+12]), 4'd1);
`ifdef PULSE_STRETCH_QUEUE_EN
    check("s4_out_c13", 4'(h_out[base+13]), 4'd1);
    check("s4_busy_c13", 4'(h_busy[base+13]), 4'd1);
    check("s4_pend_c13", 4'(h_pend[base+13]), 4'd0);
    check("s4_out_c20", 4'(h_out[base+20]), 4'd1);
`else
    check("s4_drop_c13", 4'(h_drop[base+13]), 4'd1);
    check("s4_out_c13", 4'(h_out[base+13]), 4'd0);
    check("s4_busy_c13", 4'(h_busy[base+13]), 4'd0);
`endif

    // Reset in the middle of a pulse with events queued.
    do_reset();
    tick(1'b1, 1'b0);
    base = cyc;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    idle(15);
`ifdef PULSE_STRETCH_QUEUE_EN
    check("s5_pend_c4", 4'(h_pend[base+4]), 4'd2);
`endif
    check("s5_out_c4", 4'(h_out[base+4]), 4'd1);
    check("s5_out_c5", 4'(h_out[base+5]), 4'd0);
    check("s5_busy_c5", 4'(h_busy[base+5]), 4'd0);
    check("s5_pend_c5", 4'(h_pend[base+5]), 4'd0);
    check("s5_out_c12", 4'(h_out[base+12]), 4'd0);
    check("s5_busy_c15", 4'(h_busy[base+15]), 4'd0);

    // Randomized traffic with varying event density and rare resets.
    dens = 10;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) dens = $urandom_range(2, 70);
      tick(($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0,
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Output-side counterpart of the push-button debouncer: takes single-cycle event strobes (e.g. PB_down/PB_up, counter carry) and converts each into a long, human-visible pulse on a physical pin (LED, buzzer, scope probe). Each event produces exactly one on-interval followed by a guaranteed off-gap, so back-to-back events stay distinguishable. Events arriving while a pulse is in progress are queued in a saturating pending counter. Sits between the core logic and the board I/O.

## Interface

- ON_W, 16: on-time counter width; on-interval = 2^ON_W cycles
- OFF_W, 16: gap counter width; off-gap = 2^OFF_W cycles
- QDEPTH_W, 4: pending-counter width; max queued events = 2^QDEPTH_W - 1
- CLK  input  1  clock; all logic on posedge CLK
- RST  input  1  reset, synchronous, active-high
- EV  input  1  event strobe; every cycle sampled high is one event
- OUT  output  1  stretched pulse, active-high, registered
- BUSY  output  1  high whenever state != IDLE, registered
- DROP  output  1  one-cycle pulse: an event was discarded
- PEND  output  QDEPTH_W  number of queued events, registered

## Operation

- States: IDLE, ON, GAP. One shared counter CNT, width max(ON_W, OFF_W).
- IDLE: OUT=0. EV=1 -> ON, CNT=0.
- ON: OUT=1, CNT increments. When CNT == 2^ON_W-1 -> GAP, CNT=0.
- GAP: OUT=0, CNT increments. When CNT == 2^OFF_W-1: if PEND>0 (after counting the same-cycle EV) -> ON, CNT=0, PEND decrements; else -> IDLE.
- EV=1 while in ON or GAP: PEND increments; if PEND already at max, PEND holds and DROP pulses.
- GAP terminal cycle with EV=1: event counted and one consumed in the same cycle; net PEND unchanged, state -> ON. Works with PEND=0 (event starts the next pulse directly).
- Arithmetic: CNT and PEND unsigned, never wrap; PEND saturates at 2^QDEPTH_W-1 and never goes below 0.
- EV held high N cycles = N events.

## Timing

- Reset values: OUT=0, BUSY=0, DROP=0, PEND=0, state IDLE, CNT=0.
- Latency EV (IDLE) -> OUT high: 1 cycle. OUT high for exactly 2^ON_W consecutive cycles, then low for exactly 2^OFF_W cycles minimum.
- Queued pulse: OUT rises on the cycle after the last GAP cycle; no extra idle cycle.
- BUSY rises with OUT, falls the cycle after the last GAP cycle when nothing is pending.
- DROP asserted the cycle after the discarded EV, exactly one cycle per discarded event.
- RST mid-pulse: next cycle all outputs at reset values; queued events lost; EV in the RST cycle ignored.

## Configuration

- PULSE_STRETCH_QUEUE_EN defined: pending counter as above.
- Not defined: no queue; PEND tied to 0; any EV while BUSY is discarded with DROP; GAP terminal cycle always -> IDLE, except EV in that exact cycle is discarded (DROP) and the block returns to IDLE.

## Structure

- Package pulse_stretch_pkg: state typedef (IDLE=2'b00, ON=2'b01, GAP=2'b10), state width constant.
- Sub-module sat_updown: saturating up/down counter (inc, dec, value, sat flag), width parameter; instantiated for PEND only under PULSE_STRETCH_QUEUE_EN.

## Test plan

Bench parameters ON_W=3 (8 cycles), OFF_W=2 (4 cycles), QDEPTH_W=2 (max 3).
- Single EV in IDLE at cycle 0 -> OUT high cycles 1-8, low 9-12, BUSY low from cycle 13, PEND=0, DROP never.
- Two EVs at cycles 0 and 3 -> PEND=1 from cycle 4; OUT high 1-8, low 9-12, high 13-20, low 21-24; PEND=0 from cycle 13.
- EV held high 5 cycles from IDLE -> 1 started, PEND reaches 3, one DROP pulse at cycle 5; total four 8-cycle pulses.
- EV exactly on last GAP cycle (cycle 12) with PEND=0 -> OUT high from cycle 13, no IDLE cycle, PEND stays 0.
- RST at cycle 4 mid-ON with PEND=2 -> cycle 5: OUT=0, BUSY=0, PEND=0; no further pulses.
- Macro undefined: EVs at cycles 0 and 3 -> one pulse only, DROP at cycle 4, PEND constant 0.
